// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared constants and types for the fetch-stage PC redirect controller.
// Holds PC select codes, controller state encodings and the pending-redirect record.
package pc_redirect_ctrl_pkg;

    localparam logic [1:0] SEL_ADD4    = 2'b00;
    localparam logic [1:0] SEL_NPC     = 2'b01;
    localparam logic [1:0] SEL_NPC_REG = 2'b10;

    localparam logic [1:0] ST_RUN   = 2'b00;
    localparam logic [1:0] ST_HOLD  = 2'b01;
    localparam logic [1:0] ST_FLUSH = 2'b10;

    localparam logic KIND_BR = 1'b0;
    localparam logic KIND_JR = 1'b1;

    typedef struct packed {
        logic        kind;
        logic [31:0] target;
    } pend_t;

endpackage

// File: rtl/pc_redirect_ctrl_if.sv
// Request/control bundle between hazard/ID/CP0 logic and the PC redirect controller.
// master drives the requests; slave (the controller) drives the PC controls.
interface pc_redirect_ctrl_if;

    logic        stall;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc;
    logic        br_req;
    logic [31:0] br_target;
    logic        jr_req;
    logic [31:0] jr_target;
    logic        pc_hold;
    logic [1:0]  pc_sel;
    logic [31:0] redir_pc;
    logic [31:0] redir_reg;
    logic        flush_if;
    logic        busy;

    modport master (
        output stall, exc_req, eret_req, epc,
        output br_req, br_target, jr_req, jr_target,
        input  pc_hold, pc_sel, redir_pc, redir_reg,
        input  flush_if, busy
    );

    modport slave (
        input  stall, exc_req, eret_req, epc,
        input  br_req, br_target, jr_req, jr_target,
        output pc_hold, pc_sel, redir_pc, redir_reg,
        output flush_if, busy
    );

endinterface

// File: rtl/pc_redirect_ctrl.sv
// Fetch-stage PC sequencer: arbitrates exc/eret/jr/br redirects against stalls.
// Parks a redirect seen under stall and replays it once the stall releases.
module pc_redirect_ctrl
    import pc_redirect_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_PC       = 32'h0000_4180,
    parameter int          FLUSH_CYCLES = 1
) (
    input  logic               clk,
    input  logic               reset,
    pc_redirect_ctrl_if.slave  bus
);

    localparam logic [2:0] CNT_LOAD = 3'(FLUSH_CYCLES - 1);

    logic [1:0] state_q, state_d;
    pend_t      pend_q, pend_d;
    logic [2:0] cnt_q, cnt_d;

    logic       trap;
    logic       pc_hold;
    logic [1:0] pc_sel;
    logic [31:0] redir_pc;
    logic [31:0] redir_reg;
    logic       flush_if;

    assign trap = bus.exc_req | bus.eret_req;

    // Next-state and same-cycle PC control decode.
    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        cnt_d     = cnt_q;
        pc_hold   = 1'b0;
        pc_sel    = SEL_ADD4;
        redir_pc  = 32'h0;
        redir_reg = 32'h0;
        flush_if  = 1'b0;
        if (trap) begin
            pc_sel   = SEL_NPC;
            redir_pc = bus.exc_req ? EXC_PC : bus.epc;
            flush_if = 1'b1;
            state_d  = ST_FLUSH;
            cnt_d    = CNT_LOAD;
            pend_d   = '0;
        end else begin
            unique case (state_q)
                ST_HOLD: begin
                    if (bus.stall) begin
                        pc_hold = 1'b1;
                    end else begin
                        if (pend_q.kind == KIND_JR) begin
                            pc_sel    = SEL_NPC_REG;
                            redir_reg = pend_q.target;
                        end else begin
                            pc_sel   = SEL_NPC;
                            redir_pc = pend_q.target;
                        end
                        pend_d  = '0;
                        state_d = ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    flush_if = 1'b1;
                    pc_hold  = bus.stall;
                    if (cnt_q == 3'd0) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                default: begin
                    if (bus.stall) begin
                        pc_hold = 1'b1;
                        if (bus.jr_req) begin
                            pend_d  = '{kind: KIND_JR,
                                        target: bus.jr_target};
                            state_d = ST_HOLD;
                        end else if (bus.br_req) begin
                            pend_d  = '{kind: KIND_BR,
                                        target: bus.br_target};
                            state_d = ST_HOLD;
                        end
                    end else if (bus.jr_req) begin
                        pc_sel    = SEL_NPC_REG;
                        redir_reg = bus.jr_target;
                    end else if (bus.br_req) begin
                        pc_sel   = SEL_NPC;
                        redir_pc = bus.br_target;
                    end
                end
            endcase
        end
    end

    // State, pending redirect and flush counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            pend_q  <= '0;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.pc_hold   = pc_hold;
    assign bus.pc_sel    = pc_sel;
    assign bus.redir_pc  = redir_pc;
    assign bus.redir_reg = redir_reg;
    assign bus.flush_if  = flush_if;
    assign bus.busy      = (state_q != ST_RUN);

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl.
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_pc_redirect_ctrl;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    pc_redirect_ctrl_if bus();

    pc_redirect_ctrl #(
        .EXC_PC       (32'h0000_4180),
        .FLUSH_CYCLES (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.stall     = 1'b0;
        bus.exc_req   = 1'b0;
        bus.eret_req  = 1'b0;
        bus.epc       = 32'h0;
        bus.br_req    = 1'b0;
        bus.br_target = 32'h0;
        bus.jr_req    = 1'b0;
        bus.jr_target = 32'h0;
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic outs(input string tag,
                        input logic hold,
                        input logic [1:0] sel,
                        input logic [31:0] rpc,
                        input logic [31:0] rreg,
                        input logic fl,
                        input logic bsy);
        #1;
        chk({tag, ".hold"}, 32'(bus.pc_hold), 32'(hold));
        chk({tag, ".sel"}, 32'(bus.pc_sel), 32'(sel));
        chk({tag, ".rpc"}, bus.redir_pc, rpc);
        chk({tag, ".rreg"}, bus.redir_reg, rreg);
        chk({tag, ".flush"}, 32'(bus.flush_if), 32'(fl));
        chk({tag, ".busy"}, 32'(bus.busy), 32'(bsy));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        idle();
        #2;
        outs("rst", 0, 2'b00, 0, 0, 0, 0);
        nxt();
        reset = 1'b1;
        outs("idle", 0, 2'b00, 0, 0, 0, 0);

        // branch, no stall
        nxt();
        bus.br_req    = 1'b1;
        bus.br_target = 32'h3010;
        outs("br", 0, 2'b01, 32'h3010, 0, 0, 0);

        // jr beats br in the same cycle
        nxt();
        bus.jr_req    = 1'b1;
        bus.jr_target = 32'h3200;
        outs("jrbr", 0, 2'b10, 0, 32'h3200, 0, 0);

        // jr under 3 stall cycles then release
        nxt();
        idle();
        bus.stall     = 1'b1;
        bus.jr_req    = 1'b1;
        bus.jr_target = 32'h3100;
        outs("jrs1", 1, 2'b00, 0, 0, 0, 0);
        nxt();
        outs("jrs2", 1, 2'b00, 0, 0, 0, 1);
        nxt();
        bus.br_req    = 1'b1;
        bus.br_target = 32'h3999;
        outs("jrs3", 1, 2'b00, 0, 0, 0, 1);
        nxt();
        bus.stall     = 1'b0;
        bus.jr_target = 32'h3300;
        outs("jrrel", 0, 2'b10, 0, 32'h3100, 0, 1);
        nxt();
        idle();
        outs("jrdone", 0, 2'b00, 0, 0, 0, 0);

        // exception beats stall and br
        nxt();
        bus.exc_req   = 1'b1;
        bus.stall     = 1'b1;
        bus.br_req    = 1'b1;
        bus.br_target = 32'h5555;
        outs("exc", 0, 2'b01, 32'h4180, 0, 1, 0);
        nxt();
        idle();
        bus.stall  = 1'b1;
        bus.jr_req = 1'b1;
        bus.jr_target = 32'h7000;
        outs("excfl", 1, 2'b00, 0, 0, 1, 1);
        nxt();
        idle();
        outs("excrun", 0, 2'b00, 0, 0, 0, 0);

        // eret overrides pending br in HOLD
        nxt();
        bus.stall     = 1'b1;
        bus.br_req    = 1'b1;
        bus.br_target = 32'h3020;
        outs("hbr", 1, 2'b00, 0, 0, 0, 0);
        nxt();
        bus.eret_req = 1'b1;
        bus.epc      = 32'h3040;
        outs("heret", 0, 2'b01, 32'h3040, 0, 1, 1);
        nxt();
        idle();
        outs("herfl", 0, 2'b00, 0, 0, 1, 1);
        nxt();
        outs("hernr", 0, 2'b00, 0, 0, 0, 0);

        // exc beats eret beats jr; eret re-redirects in FLUSH
        nxt();
        bus.exc_req  = 1'b1;
        bus.eret_req = 1'b1;
        bus.epc      = 32'h2222;
        bus.jr_req   = 1'b1;
        bus.jr_target = 32'h6000;
        outs("prio", 0, 2'b01, 32'h4180, 0, 1, 0);
        nxt();
        idle();
        bus.eret_req = 1'b1;
        bus.epc      = 32'h1234;
        outs("refl", 0, 2'b01, 32'h1234, 0, 1, 1);
        nxt();
        idle();
        outs("refl2", 0, 2'b00, 0, 0, 1, 1);
        nxt();
        bus.eret_req  = 1'b1;
        bus.epc       = 32'h0ABC;
        bus.jr_req    = 1'b1;
        bus.jr_target = 32'h6000;
        outs("eretjr", 0, 2'b01, 32'h0ABC, 0, 1, 0);
        nxt();
        idle();
        outs("eretfl", 0, 2'b00, 0, 0, 1, 1);
        nxt();
        outs("eretrun", 0, 2'b00, 0, 0, 0, 0);

        // async reset mid-HOLD
        nxt();
        bus.stall     = 1'b1;
        bus.br_req    = 1'b1;
        bus.br_target = 32'h3020;
        outs("rhbr", 1, 2'b00, 0, 0, 0, 0);
        nxt();
        outs("rhold", 1, 2'b00, 0, 0, 0, 1);
        idle();
        reset = 1'b0;
        outs("rasync", 0, 2'b00, 0, 0, 0, 0);
        nxt();
        reset = 1'b1;
        outs("rrel", 0, 2'b00, 0, 0, 0, 0);
        nxt();
        outs("rnorep", 0, 2'b00, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
